snow64_alu_issue_stage: RTL and testbench

SNOW64_ALU_ISSUE_STAGE -- requirements
Module: snow64_alu_issue_stage

---
 rtl/snow64_alu_issue_stage.sv | 122 ++++++++++++
 tb/tb_snow64_alu_issue_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_alu_issue_stage.sv
// Issue stage in front of a combinational 64-bit ALU: a small request FIFO
// whose head feeds the ALU, plus one output register holding the retired result.
module snow64_alu_issue_stage #(
  parameter int QUEUE_DEPTH = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_a,
  input  logic [63:0]          in_b,
  input  logic [3:0]           in_oper,
  input  logic [1:0]           in_type_size,
  input  logic                 in_signedness,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [63:0]          to_alu_a,
  output logic [63:0]          to_alu_b,
  output logic [3:0]           to_alu_oper,
  output logic [1:0]           to_alu_type_size,
  output logic                 to_alu_signedness,
  input  logic [63:0]          from_alu_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_illegal,
  output logic [15:0]          illegal_count
);
  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [63:0]          a;
    logic [63:0]          b;
    logic [3:0]           oper;
    logic [1:0]           sz;
    logic                 sgn;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  req_t            r_mem [QUEUE_DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [PW:0]     r_cnt;
  logic            r_ov, r_oi;
  logic [63:0]     r_od;
  logic [TAG_WIDTH-1:0] r_ot;
  logic [15:0]     r_icnt;

  logic w_empty, w_full, w_push, w_ret, w_illegal;
  req_t w_head, w_in;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == (PW+1)'(QUEUE_DEPTH));
  assign in_ready = ~w_full & ~rst;
  assign w_push   = in_valid & in_ready;
  assign w_ret    = ~w_empty & (~r_ov | out_ready);
  assign w_head   = r_mem[r_head];
  assign w_in     = '{a: in_a, b: in_b, oper: in_oper, sz: in_type_size,
                      sgn: in_signedness, tag: in_tag};

  // Illegal heads are still presented to the ALU; only the result is discarded.
  assign to_alu_a          = w_empty ? '0 : w_head.a;
  assign to_alu_b          = w_empty ? '0 : w_head.b;
  assign to_alu_oper       = w_empty ? '0 : w_head.oper;
  assign to_alu_type_size  = w_empty ? '0 : w_head.sz;
  assign to_alu_signedness = w_empty ? '0 : w_head.sgn;

  always_comb begin
    w_illegal = 1'b0;
    case (w_head.oper)
      4'd3, 4'd4, 4'd13, 4'd14, 4'd15: w_illegal = 1'b1;
      default:                         w_illegal = 1'b0;
    endcase
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_ret)  r_head <= r_head + 1'b1;
      case ({w_push, w_ret})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov   <= 1'b0;
      r_od   <= '0;
      r_ot   <= '0;
      r_oi   <= 1'b0;
      r_icnt <= '0;
    end else begin
      if (w_ret) begin
        r_ov <= 1'b1;
        r_ot <= w_head.tag;
        r_od <= w_illegal ? 64'd0 : from_alu_data;
        r_oi <= w_illegal;
        if (w_illegal && r_icnt != 16'hFFFF) r_icnt <= r_icnt + 1'b1;
      end else if (r_ov && out_ready) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign out_valid     = r_ov;
  assign out_data      = r_od;
  assign out_tag       = r_ot;
  assign out_illegal   = r_oi;
  assign illegal_count = r_icnt;
endmodule

// File: tb/tb_snow64_alu_issue_stage.sv
// Bench for snow64_alu_issue_stage: transaction-level queue model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_snow64_alu_issue_stage;
  localparam int DEPTH = 2;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_a = '0, in_b = '0;
  logic [3:0]    in_oper = '0;
  logic [1:0]    in_type_size = '0;
  logic          in_signedness = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic [63:0]   to_alu_a, to_alu_b;
  logic [3:0]    to_alu_oper;
  logic [1:0]    to_alu_type_size;
  logic          to_alu_signedness;
  logic [63:0]   from_alu_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
  logic [15:0]   illegal_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snow64_alu_issue_stage #(.QUEUE_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_oper(in_oper),
    .in_type_size(in_type_size), .in_signedness(in_signedness), .in_tag(in_tag),
    .to_alu_a(to_alu_a), .to_alu_b(to_alu_b), .to_alu_oper(to_alu_oper),
    .to_alu_type_size(to_alu_type_size), .to_alu_signedness(to_alu_signedness),
    .from_alu_data(from_alu_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  // Stand-in combinational ALU.
  function automatic logic [63:0] alu(logic [63:0] a, logic [63:0] b, logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b ^ 64'(op);
    endcase
  endfunction

  function automatic bit is_ill(logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4) || (op >= 4'd13);
  endfunction

  assign from_alu_data = alu(to_alu_a, to_alu_b, to_alu_oper);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO of pending requests plus one output slot.
  typedef struct {
    logic [63:0]   a, b;
    logic [3:0]    op;
    logic [1:0]    sz;
    logic          sgn;
    logic [TW-1:0] tag;
  } req_t;

  req_t          mq[$];
  req_t          m_h, m_cur;
  bit            m_ret, m_psh;
  logic          m_ov = 1'b0, m_oi = 1'b0;
  logic [63:0]   m_od = '0;
  logic [TW-1:0] m_ot = '0;
  logic [15:0]   m_cnt = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_ov = 1'b0; m_oi = 1'b0; m_od = '0; m_ot = '0; m_cnt = '0;
      end else begin
        m_psh = in_valid && (mq.size() < DEPTH);
        m_ret = (mq.size() != 0) && (!m_ov || out_ready);
        m_cur = '{a: in_a, b: in_b, op: in_oper, sz: in_type_size,
                  sgn: in_signedness, tag: in_tag};
        if (m_ret) begin
          m_h  = mq.pop_front();
          m_ov = 1'b1;
          m_ot = m_h.tag;
          m_oi = is_ill(m_h.op);
          m_od = m_oi ? 64'd0 : alu(m_h.a, m_h.b, m_h.op);
          if (m_oi && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_ov && out_ready) begin
          m_ov = 1'b0;
        end
        if (m_psh) mq.push_back(m_cur);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!rst && mq.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", out_data, m_od);
    chk("out_tag", 64'(out_tag), 64'(m_ot));
    chk("out_illegal", 64'(out_illegal), 64'(m_oi));
    chk("illegal_count", 64'(illegal_count), 64'(m_cnt));
    if (mq.size() != 0) begin
      chk("to_alu_a", to_alu_a, mq[0].a);
      chk("to_alu_b", to_alu_b, mq[0].b);
      chk("to_alu_ctl", {57'd0, to_alu_oper, to_alu_type_size, to_alu_signedness},
          {57'd0, mq[0].op, mq[0].sz, mq[0].sgn});
    end else begin
      chk("to_alu_idle", to_alu_a | to_alu_b |
          64'({to_alu_oper, to_alu_type_size, to_alu_signedness}), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic [63:0] a, logic [63:0] b, logic [3:0] op, logic [TW-1:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_oper = op; in_tag = tag;
    in_type_size = 2'd3; in_signedness = tag[0];
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_illegal_count", 64'(illegal_count), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single op: 5 + 3
    set_req(64'd5, 64'd3, 4'd0, 4'd1);
    step();
    in_valid = 1'b0;
    chk("single_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", out_data, 64'd8);
    chk("single_tag", 64'(out_tag), 64'd1);
    chk("single_illegal", 64'(out_illegal), 64'd0);
    step();

    // Backpressure: two in the queue, one held in the output register
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(64'(10 + i), 64'd1, 4'd1, TW'(i));
      step();
    end
    in_valid = 1'b0;
    chk("bp_full", 64'(in_ready), 64'd0);
    chk("bp_tag0", 64'(out_tag), 64'd0);
    chk("bp_data0", out_data, 64'd9);
    out_ready = 1'b1;
    step();
    chk("bp_tag1", 64'(out_tag), 64'd1);
    step();
    chk("bp_tag2", 64'(out_tag), 64'd2);
    chk("bp_data2", out_data, 64'd11);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Illegal opcode
    set_req(64'd100, 64'd200, 4'd13, 4'd7);
    step();
    in_valid = 1'b0;
    step();
    chk("ill_data", out_data, 64'd0);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_tag", 64'(out_tag), 64'd7);
    chk("ill_count", 64'(illegal_count), 64'd1);
    // Opcode 12 stays legal
    set_req(64'd6, 64'd3, 4'd12, 4'd2);
    step();
    in_valid = 1'b0;
    step();
    chk("op12_legal", 64'(out_illegal), 64'd0);
    chk("op12_data", out_data, 64'd6 ^ 64'd3 ^ 64'd12);
    step();

    // Streaming: 16 back-to-back, one result per cycle
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) set_req(64'(i * 3), 64'(i), 4'(i % 2), TW'(i));
      else in_valid = 1'b0;
      step();
      if (i >= 1) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_tag", 64'(out_tag), 64'(i - 1));
      end
    end
    step();

    // Reset mid-stream with two queued and a result pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(64'(i), 64'd0, 4'd13, TW'(i + 5));
      step();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_data", out_data, 64'd0);
    chk("mid_tag", 64'(out_tag), 64'd0);
    chk("mid_illegal", 64'(out_illegal), 64'd0);
    chk("mid_count", 64'(illegal_count), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd0);
    chk("mid_to_alu", to_alu_a | 64'(to_alu_oper), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // Saturation: 65540 illegal retires
    for (int i = 0; i < 65540; i++) begin
      set_req(64'(i), 64'd1, 4'd14, TW'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_count", 64'(illegal_count), 64'hFFFF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
